// File: rtl/sfr_bank_ta.sv
// Bank of NUM_REGS byte/bit-writable 8051-style SFRs. Define SFR_BANK_TIMED_ACCESS_EN to
// build the Timed Access (0xAA/0x55) unlock guarding the PROT_MASK registers.
module sfr_bank_ta #(
  parameter int unsigned         NUM_REGS  = 4,
  parameter logic [7:0]          BASE_ADDR = 8'hC8,
  parameter logic [NUM_REGS-1:0] PROT_MASK = '0,
  parameter logic [7:0]          TA_ADDR   = 8'hC7,
  parameter int unsigned         TA_WINDOW = 3,
  parameter logic [7:0]          RESET_VAL = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            data_in,
  input  logic [7:0]            addr,
  input  logic                  wr_en,
  input  logic                  wr_bit_en,
  input  logic                  bit_in,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic [7:0]            rd_data,
  output logic                  rd_hit,
  output logic                  ta_open,
  output logic                  prot_err
);

  if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
    $error("sfr_bank_ta: NUM_REGS must be 1..8");
  end
  if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base_align
    $error("sfr_bank_ta: BASE_ADDR must be 8-aligned");
  end
  if (int'(BASE_ADDR) + 8 * (int'(NUM_REGS) - 1) > 255) begin : g_bad_base_wrap
    $error("sfr_bank_ta: bank wraps past 8'hFF");
  end
  if (TA_WINDOW < 1) begin : g_bad_window
    $error("sfr_bank_ta: TA_WINDOW must be >= 1");
  end
  if (TA_ADDR[2:0] == 3'b000 && TA_ADDR >= BASE_ADDR &&
      (int'(TA_ADDR) - int'(BASE_ADDR)) / 8 < int'(NUM_REGS)) begin : g_bad_ta_addr
    $error("sfr_bank_ta: TA_ADDR collides with a bank register");
  end
  if ($bits(PROT_MASK) != NUM_REGS) begin : g_bad_prot_mask
    $error("sfr_bank_ta: PROT_MASK width must equal NUM_REGS");
  end

  function automatic logic [7:0] reg_addr(input int unsigned idx);
    return BASE_ADDR + 8'(8 * idx);
  endfunction

  logic [7:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0] byte_sel;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] wr_ok;

  // Bit writes match on addr[7:3] only; addr[2:0] then picks the bit.
  always_comb begin
    logic [7:0] ra;
    ra       = '0;
    byte_sel = '0;
    wr_sel   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ra          = reg_addr(i);
      byte_sel[i] = (addr == ra);
      wr_sel[i]   = wr_en & (wr_bit_en ? (addr[7:3] == ra[7:3]) : byte_sel[i]);
    end
  end

`ifdef SFR_BANK_TIMED_ACCESS_EN
  localparam int unsigned CW = (TA_WINDOW > 1) ? $clog2(TA_WINDOW) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TA_WINDOW - 1);

  typedef enum logic [1:0] {IDLE, ARMED, OPEN} ta_state_t;

  ta_state_t      state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           ta_wr;
  logic           prot_wr;

  assign ta_wr   = wr_en & ~wr_bit_en & (addr == TA_ADDR);
  assign prot_wr = |(wr_sel & PROT_MASK);
  assign wr_ok   = wr_sel & (~PROT_MASK | {NUM_REGS{state == OPEN}});
  assign ta_open = (state == OPEN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ta_wr) begin
      if (data_in == 8'hAA) begin
        state_nxt = ARMED;
        cnt_nxt   = CNT_LOAD;
      end else if (state == ARMED && data_in == 8'h55) begin
        state_nxt = OPEN;
        cnt_nxt   = CNT_LOAD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else if (state == OPEN && prot_wr) begin
      // The single protected write consumes the unlock.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state != IDLE) begin
      if (cnt == '0) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prot_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      prot_err <= prot_wr & (state != OPEN);
    end
  end
`else
  assign wr_ok    = wr_sel;
  assign ta_open  = 1'b0;
  assign prot_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_ok[i]) begin
          if (wr_bit_en) begin
            regs[i][addr[2:0]] <= bit_in;
          end else begin
            regs[i] <= data_in;
          end
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs[i];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (byte_sel[i]) begin
        rd_data = regs[i];
        rd_hit  = 1'b1;
      end
    end
`ifdef SFR_BANK_TIMED_ACCESS_EN
    if (addr == TA_ADDR) begin
      rd_data = {7'b0, ta_open};
      rd_hit  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_sfr_bank_ta.sv
// Randomized self-checking bench for sfr_bank_ta against a cycle-count reference model;
// follows the DUT build (SFR_BANK_TIMED_ACCESS_EN defined or not).
module tb_sfr_bank_ta;
  localparam int unsigned NR = 4;
  localparam int          W  = 3;
  localparam logic [3:0]  PM = 4'b0100;
`ifdef SFR_BANK_TIMED_ACCESS_EN
  localparam bit TA_EN = 1'b1;
`else
  localparam bit TA_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    data_in, addr;
  logic          wr_en, wr_bit_en, bit_in;
  logic [8*NR-1:0] regs_flat;
  logic [7:0]    rd_data;
  logic          rd_hit, ta_open, prot_err;

  sfr_bank_ta #(
    .NUM_REGS (NR),
    .BASE_ADDR(8'hC8),
    .PROT_MASK(PM),
    .TA_ADDR  (8'hC7),
    .TA_WINDOW(W),
    .RESET_VAL(8'h00)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .addr     (addr),
    .wr_en    (wr_en),
    .wr_bit_en(wr_bit_en),
    .bit_in   (bit_in),
    .regs_flat(regs_flat),
    .rd_data  (rd_data),
    .rd_hit   (rd_hit),
    .ta_open  (ta_open),
    .prot_err (prot_err)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: remaining armed/open cycles instead of an explicit state.
  logic [7:0] m_regs [NR];
  int         m_armed, m_open;
  bit         m_perr;

  function automatic int bank_idx(input logic [7:0] a, input bit bitmode);
    for (int i = 0; i < int'(NR); i++) begin
      int base = 'hC8 + 8 * i;
      if (bitmode ? (int'(a) / 8 == base / 8) : (int'(a) == base)) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_flat();
    logic [31:0] f = '0;
    for (int i = 0; i < int'(NR); i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = 8'h00;
    m_armed = 0;
    m_open  = 0;
    m_perr  = 1'b0;
  endtask

  task automatic model_rd(input logic [7:0] a, output bit hit, output logic [7:0] d);
    int idx = bank_idx(a, 1'b0);
    hit = 1'b0;
    d   = 8'h00;
    if (idx >= 0) begin
      hit = 1'b1;
      d   = m_regs[idx];
    end else if (TA_EN && a == 8'hC7) begin
      hit = 1'b1;
      d   = {7'b0, m_open > 0};
    end
  endtask

  task automatic model_edge(input bit we, input bit bm, input logic [7:0] a,
                            input logic [7:0] d, input bit b);
    int idx = bank_idx(a, bm);
    bit ta_wr = TA_EN && we && !bm && a == 8'hC7;
    bit used  = 1'b0;
    m_perr = 1'b0;
    if (we && idx >= 0) begin
      if (!(TA_EN && PM[idx]) || m_open > 0) begin
        if (bm) m_regs[idx][a % 8] = b;
        else    m_regs[idx] = d;
        used = TA_EN && PM[idx];
      end else begin
        m_perr = 1'b1;
      end
    end
    if (ta_wr) begin
      if (d == 8'hAA) begin
        m_armed = W; m_open = 0;
      end else if (d == 8'h55 && m_armed > 0) begin
        m_open = W; m_armed = 0;
      end else begin
        m_armed = 0; m_open = 0;
      end
    end else if (used) begin
      m_open = 0;
    end else begin
      if (m_armed > 0) m_armed--;
      if (m_open > 0)  m_open--;
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input bit we, input bit bm, input logic [7:0] a,
                       input logic [7:0] d, input bit b, input string tag);
    bit         eh;
    logic [7:0] ed;
    wr_en = we; wr_bit_en = bm; addr = a; data_in = d; bit_in = b;
    #1;
    model_rd(a, eh, ed);
    check({tag, ".rd_data"}, 32'(rd_data), 32'(ed));
    check({tag, ".rd_hit"}, 32'(rd_hit), 32'(eh));
    @(posedge clock);
    model_edge(we, bm, a, d, b);
    #1;
    check({tag, ".regs"}, 32'(regs_flat), m_flat());
    check({tag, ".ta_open"}, 32'(ta_open), 32'(m_open > 0));
    check({tag, ".prot_err"}, 32'(prot_err), 32'(m_perr));
    @(negedge clock);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] ra, rd;
    int         op, ri;
    reset = 1'b1;
    wr_en = 1'b0; wr_bit_en = 1'b0; addr = 8'h00; data_in = 8'h00; bit_in = 1'b0;
    model_reset();
    #12;
    check("reset.regs", 32'(regs_flat), 32'h0);
    check("reset.ta_open", 32'(ta_open), 32'h0);
    check("reset.prot_err", 32'(prot_err), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int a = 0; a < 256; a++) idle_sweep(8'(a));

    cycle(1'b1, 1'b0, 8'hD0, 8'h5A, 1'b0, "byte_d0");
    cycle(1'b1, 1'b1, 8'hD1, 8'h00, 1'b0, "bit_d1");
    check("reg1_after_bitwr", 32'(regs_flat[15:8]), 32'h58);

    cycle(1'b1, 1'b0, 8'hD8, 8'hFF, 1'b0, "prot_locked");
    idle("prot_locked_p1");
    idle("prot_locked_p2");

    cycle(1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, "unlock_aa");
    cycle(1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, "unlock_55");
    idle("unlock_gap");
    cycle(1'b1, 1'b0, 8'hD8, 8'h3C, 1'b0, "unlock_wr");
    idle("unlock_after");
    check("reg2_unlocked", 32'(regs_flat[23:16]), 32'h3C);

    cycle(1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, "expire_aa");
    idle("expire_w1"); idle("expire_w2"); idle("expire_w3");
    cycle(1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, "expire_55");
    cycle(1'b1, 1'b0, 8'hD8, 8'h77, 1'b0, "expire_wr");
    idle("expire_after");

    cycle(1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, "tabit_aa");
    cycle(1'b1, 1'b1, 8'hC7, 8'h00, 1'b1, "tabit_bit");
    cycle(1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, "tabit_55");
    cycle(1'b1, 1'b1, 8'hDB, 8'h00, 1'b1, "tabit_bitwr");
    idle("tabit_after");

    cycle(1'b1, 1'b0, 8'hC8, 8'h11, 1'b0, "rst_pre_c8");
    cycle(1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, "rst_aa");
    cycle(1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, "rst_55");
    wr_en = 1'b1; wr_bit_en = 1'b0; addr = 8'hD8; data_in = 8'h99;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("midrst.ta_open", 32'(ta_open), 32'h0);
    check("midrst.regs", 32'(regs_flat), m_flat());
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 8'hD8, 8'hA5, 1'b0, "postrst_wr");
    idle("postrst_after");

    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 9));
      ri = int'($urandom_range(0, NR - 1));
      ra = 8'hC8 + 8'(8 * ri);
      rd = 8'($urandom);
      case (op)
        0: cycle(1'b1, 1'b0, 8'hC7, 8'hAA, 1'b0, "rnd_aa");
        1: cycle(1'b1, 1'b0, 8'hC7, 8'h55, 1'b0, "rnd_55");
        2: cycle(1'b1, 1'b0, 8'hC7, rd, 1'b0, "rnd_tadata");
        3, 4: cycle(1'b1, 1'b0, ra, rd, 1'b0, "rnd_byte");
        5, 6: cycle(1'b1, 1'b1, ra | 8'($urandom_range(0, 7)), rd, rd[0], "rnd_bit");
        7: cycle(1'b1, 1'($urandom), 8'($urandom), rd, rd[1], "rnd_any");
        default: cycle(1'b0, 1'($urandom), 8'($urandom), rd, rd[2], "rnd_idle");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic idle_sweep(input logic [7:0] a);
    cycle(1'b0, 1'b0, a, 8'hFF, 1'b1, "sweep");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
